cpu_memory_responder: RTL and testbench

Memory-side responder for the CPU request/ready bus used by the instruction fetch stage. Accepts a level-held request with a word address, services it from an internal word-organised RAM after a programmable number of wait states, and returns data with a single-cycle ready pulse. Sits between the fetch (or load/store) initiator and on-chip block RAM. Optional write support allows the same block to serve as data memory.

---
 rtl/cpu_bus_pkg.sv | 15 +
 rtl/cpu_memory_responder_if.sv | 25 ++
 rtl/cpu_memory_array.sv | 32 +++
 rtl/cpu_memory_responder.sv | 159 +++++++++++++++
 tb/tb_cpu_memory_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared CPU request/ready bus widths and responder state encoding
package cpu_bus_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RECOVER = 2'd3
    } cpu_state_e;

endpackage

// File: rtl/cpu_memory_responder_if.sv
// rtl/cpu_memory_responder_if.sv - CPU request/ready bus bundle with master/slave views
// Signals: i_request, i_rw, i_address, i_wdata, i_wmask (initiator -> responder),
//          o_ready, o_data (responder -> initiator). Names keep the responder's view.
interface cpu_memory_responder_if;
    import cpu_bus_pkg::*;

    logic              i_request;
    logic              i_rw;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_wdata;
    logic [MASK_W-1:0] i_wmask;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;

    modport master (
        output i_request, i_rw, i_address, i_wdata, i_wmask,
        input  o_ready, o_data
    );

    modport slave (
        input  i_request, i_rw, i_address, i_wdata, i_wmask,
        output o_ready, o_data
    );

endinterface

// File: rtl/cpu_memory_array.sv
// rtl/cpu_memory_array.sv - single-port synchronous word RAM with byte write enables
// Ports: i_clock; i_index word index; i_we per-byte write enables; i_wdata write word;
//        o_rdata registered read of i_index (one-cycle latency, old data on write).
// Contents are deliberately not reset.
module cpu_memory_array
    import cpu_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clock,
    input  logic [IDX_W-1:0]  i_index,
    input  logic [MASK_W-1:0] i_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge i_clock) begin
        for (int b = 0; b < MASK_W; b++) begin
            if (i_we[b]) begin
                mem_q[i_index][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        rdata_q <= mem_q[i_index];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/cpu_memory_responder.sv
// rtl/cpu_memory_responder.sv - wait-state memory responder for the CPU request/ready bus
// Ports: i_clock, i_reset (async, active-high), bus (cpu_memory_responder_if.slave).
// Parameters: LATENCY 1..15 wait states, RECOVERY 1..7 ignore cycles, DEPTH_WORDS power of two.
// Macro CPU_MEMORY_RESPONDER_WRITE_EN: honour i_rw/i_wdata/i_wmask; otherwise read-only ROM.
module cpu_memory_responder
    import cpu_bus_pkg::*;
#(
    parameter int LATENCY     = 1,
    parameter int RECOVERY    = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    cpu_memory_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_WAIT    = WAIT;
    localparam logic [1:0] S_ACK     = ACK;
    localparam logic [1:0] S_RECOVER = RECOVER;

    logic [1:0]        state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [2:0]        rec_cnt_q, rec_cnt_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              is_write;
    logic [IDX_W-1:0]  ram_index;
    logic [MASK_W-1:0] ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // In IDLE the RAM is addressed straight from the bus so the read launched on the
    // capture edge is already valid when LATENCY = 1 ends WAIT on the very next edge.
    assign ram_index = (state_q == S_IDLE) ? bus.i_address[IDX_W+1:2] : index_q;

    logic unused_addr;
    assign unused_addr = ^{bus.i_address[ADDR_W-1:IDX_W+2], bus.i_address[1:0]};

`ifdef CPU_MEMORY_RESPONDER_WRITE_EN
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rw_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    always_comb begin
        rw_d    = rw_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        if (state_q == S_IDLE && bus.i_request) begin
            rw_d    = bus.i_rw;
            wdata_d = bus.i_wdata;
            wmask_d = bus.i_wmask;
        end
    end

    // Write enables exist only while in ACK, so the commit happens on the edge leaving
    // ACK; an async reset before that edge leaves the RAM untouched.
    assign is_write  = rw_q;
    assign ram_we    = (state_q == S_ACK && rw_q) ? wmask_q : '0;
    assign ram_wdata = wdata_q;
`else
    logic unused_wr;
    assign unused_wr = ^{bus.i_rw, bus.i_wdata, bus.i_wmask};
    assign is_write  = 1'b0;
    assign ram_we    = '0;
    assign ram_wdata = '0;
`endif

    cpu_memory_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .i_clock (i_clock),
        .i_index (ram_index),
        .i_we    (ram_we),
        .i_wdata (ram_wdata),
        .o_rdata (ram_rdata)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            rec_cnt_q  <= '0;
            index_q    <= '0;
            ready_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rec_cnt_q  <= rec_cnt_d;
            index_q    <= index_d;
            ready_q    <= ready_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rec_cnt_d  = rec_cnt_q;
        index_d    = index_q;
        ready_d    = 1'b0;
        data_d     = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_request) begin
                    index_d    = bus.i_address[IDX_W+1:2];
                    wait_cnt_d = 4'(LATENCY - 1);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // Request level is not looked at here: a started transaction always completes.
                if (wait_cnt_q == '0) begin
                    state_d = S_ACK;
                    ready_d = 1'b1;
                    if (!is_write) begin
                        data_d = ram_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                rec_cnt_d = 3'(RECOVERY - 1);
                state_d   = S_RECOVER;
            end
            S_RECOVER: begin
                if (rec_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    rec_cnt_d = rec_cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_ready = ready_q;
    assign bus.o_data  = data_q;

endmodule

// File: tb/tb_cpu_memory_responder.sv
// tb/tb_cpu_memory_responder.sv - self-checking bench for cpu_memory_responder
module tb_cpu_memory_responder;

    localparam int LAT   = 1;
    localparam int REC   = 2;
    localparam int DEPTH = 1024;
`ifdef CPU_MEMORY_RESPONDER_WRITE_EN
    localparam bit WE = 1'b1;
`else
    localparam bit WE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_memory_responder_if bus_if ();

    cpu_memory_responder #(
        .LATENCY     (LAT),
        .RECOVERY    (REC),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] last_data;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level memory: index wraps modulo the byte size, writes merge bytes
    // and leave the returned data at its previous value.
    function automatic logic [31:0] model_txn(input logic rw, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [3:0] wmask);
        int unsigned idx;
        idx = (addr % (DEPTH * 4)) / 4;
        if (rw && WE) begin
            for (int b = 0; b < 4; b++)
                if (wmask[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            last_data = model[idx];
        end
        return last_data;
    endfunction

    // Called #1 after a rising edge with the responder idle.
    task automatic do_txn(input string name, input logic rw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          output logic [31:0] data);
        int edges;
        bit seen;
        bus_if.i_request = 1'b1;
        bus_if.i_rw      = rw;
        bus_if.i_address = addr;
        bus_if.i_wdata   = wdata;
        bus_if.i_wmask   = wmask;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            seen = bus_if.o_ready;
        end
        data = bus_if.o_data;
        bus_if.i_request = 1'b0;
        bus_if.i_address = $urandom;
        bus_if.i_wdata   = $urandom;
        check({name, " latency"}, 32'(edges), 32'(LAT + 1));
        @(posedge clk); #1;
        check({name, " pulse_width"}, {31'd0, bus_if.o_ready}, 32'd0);
        repeat (REC + 1) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] got, exp, old_val;
        int edges;
        bit seen;

        bus_if.i_request = 1'b0;
        bus_if.i_rw      = 1'b0;
        bus_if.i_address = '0;
        bus_if.i_wdata   = '0;
        bus_if.i_wmask   = '0;
        last_data        = '0;

        for (int i = 0; i < DEPTH; i++) model[i] = $urandom;
        model[1] = 32'h0101_0101;
        model[3] = 32'hDEAD_BEEF;
        model[8] = 32'hAAAA_AAAA;
        for (int i = 0; i < DEPTH; i++) dut.u_array.mem_q[i] = model[i];

        vecs[0] = '{1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101, WE ? 32'hDEAD_BEEF : 32'hAAAA_AAAA};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, WE ? 32'hAA22_AA44 : 32'hAAAA_AAAA};
        vecs[3] = '{1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'h0101_0101};
        vecs[4] = '{1'b0, 32'h0000_0007, 32'h0, 4'h0, 32'h0101_0101};
        vecs[5] = '{1'b0, 32'hFFFF_F00C, 32'h0, 4'h0, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 32'h0000_0023, 32'h5566_7788, 4'b1000, WE ? 32'hDEAD_BEEF : 32'hAAAA_AAAA};
        vecs[7] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, WE ? 32'h5522_AA44 : 32'hAAAA_AAAA};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: no ready, data at reset value.
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("idle_ready", {31'd0, bus_if.o_ready}, 32'd0);
        end
        check("idle_data", bus_if.o_data, 32'd0);

        for (int v = 0; v < 8; v++) begin
            do_txn($sformatf("vec%0d", v), vecs[v].rw, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, got);
            void'(model_txn(vecs[v].rw, vecs[v].addr, vecs[v].wdata, vecs[v].wmask));
            check($sformatf("vec%0d data", v), got, vecs[v].exp);
        end

        // Fetch-style initiator: request stays high, address steps two edges after each ready.
        bus_if.i_rw      = 1'b0;
        bus_if.i_address = 32'h0;
        bus_if.i_request = 1'b1;
        for (int k = 0; k < 8; k++) begin
            edges = 0;
            seen  = 1'b0;
            while (!seen && edges < 40) begin
                @(posedge clk); #1;
                edges++;
                seen = bus_if.o_ready;
            end
            check($sformatf("fetch%0d ready", k), {31'd0, seen}, 32'd1);
            exp = model_txn(1'b0, 32'(k * 4), 32'h0, 4'h0);
            check($sformatf("fetch%0d data", k), bus_if.o_data, exp);
            repeat (2) @(posedge clk);
            #1 bus_if.i_address = 32'((k + 1) * 4);
        end
        bus_if.i_request = 1'b0;
        repeat (REC + 3) @(posedge clk);
        #1;

        // Reset during WAIT of a write: no pulse, the write never lands.
        old_val = model[16];
        bus_if.i_rw      = 1'b1;
        bus_if.i_address = 32'h0000_0040;
        bus_if.i_wdata   = ~old_val;
        bus_if.i_wmask   = 4'hF;
        bus_if.i_request = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        bus_if.i_request = 1'b0;
        #1;
        check("rst_data", bus_if.o_data, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("rst_ready", {31'd0, bus_if.o_ready}, 32'd0);
        end
        rst = 1'b0;
        last_data = '0;
        @(posedge clk); #1;
        check("post_rst_ready", {31'd0, bus_if.o_ready}, 32'd0);
        do_txn("rst_read", 1'b0, 32'h0000_0040, 32'h0, 4'h0, got);
        exp = model_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        check("rst_read data", got, old_val);
        check("rst_read model", got, exp);

        // Random traffic against the transaction model.
        for (int t = 0; t < 40; t++) begin
            logic        rw;
            logic [31:0] addr, wdata;
            logic [3:0]  wmask;
            rw    = 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = $urandom;
            wmask = 4'($urandom_range(0, 15));
            do_txn($sformatf("rnd%0d", t), rw, addr, wdata, wmask, got);
            exp = model_txn(rw, addr, wdata, wmask);
            check($sformatf("rnd%0d data", t), got, exp);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
